// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state and bus payload types for the load/store unit.
package lsu_pkg;

  localparam int unsigned TO_CNT_W = 16;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_req_t;

  typedef struct packed {
    logic [1:0] size;
    logic       uns;
    logic [1:0] lane;
  } ld_ctl_t;

  // Reserved size 2'b11 behaves as a word access.
  function automatic logic lsu_aligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: lsu_aligned = 1'b1;
      SZ_HALF: lsu_aligned = ~lo[0];
      default: lsu_aligned = (lo == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, misalignment detection and load extraction/extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_write_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o,
  input  ld_ctl_t     ld_ctl_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ldata_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    be_o         = 4'b1111;
    wdata_o      = wdata_i;
    misaligned_o = ~lsu_aligned(size_i, addr_lo_i);
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
    if (!is_write_i) be_o = 4'b1111;
  end

  always_comb begin
    ld_byte = rdata_i[{ld_ctl_i.lane, 3'b000} +: 8];
    ld_half = ld_ctl_i.lane[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (ld_ctl_i.size)
      SZ_BYTE: ldata_o = {{24{~ld_ctl_i.uns & ld_byte[7]}}, ld_byte};
      SZ_HALF: ldata_o = {{16{~ld_ctl_i.uns & ld_half[15]}}, ld_half};
      default: ldata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one req/ack data-memory transaction per load/store, stalling the core.
// Optional ack timeout with busErr reporting is enabled by defining BUS_TIMEOUT_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [1:0]  size,
  input  logic        unsignedLoad,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busReq,
  output logic        busWe,
  output logic [31:0] busAddr,
  output logic [3:0]  busBe,
  output logic [31:0] busWdata,
  input  logic [31:0] busRdata,
  input  logic        busAck,
  output logic        stall,
  output logic [31:0] loadData,
  output logic        done,
  output logic        misaligned,
  output logic        busErr
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("load_store_unit: TIMEOUT_CYCLES must be in 2..65535");
  end

  lsu_state_e  state_q, state_d;
  bus_req_t    req_q, req_d;
  ld_ctl_t     ld_q, ld_d;
  logic [31:0] load_q, load_d;
  logic        access_c;
  logic        expire_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] ext_c;
  logic        mis_c;

  assign access_c = memRead | memWrite;

  lsu_align u_align (
    .is_write_i   (memWrite),
    .size_i       (size),
    .addr_lo_i    (addr[1:0]),
    .wdata_i      (wdata),
    .be_o         (be_c),
    .wdata_o      (wdata_c),
    .misaligned_o (mis_c),
    .ld_ctl_i     (ld_q),
    .rdata_i      (busRdata),
    .ldata_o      (ext_c)
  );

`ifdef BUS_TIMEOUT_EN
  logic [TO_CNT_W-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;

  // Counter sits at zero outside WAIT so it is clear on every WAIT entry.
  assign cnt_d    = (state_q == ST_WAIT) ? cnt_q + TO_CNT_W'(1) : '0;
  assign expire_c = (cnt_q == TO_CNT_W'(TIMEOUT_CYCLES - 1));
  assign err_d    = (state_q == ST_WAIT) & ~busAck & expire_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign busErr = err_q;
`else
  assign expire_c = 1'b0;
  assign busErr   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      ld_q    <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      ld_q    <= ld_d;
      load_q  <= load_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    ld_d       = ld_q;
    load_d     = load_q;
    stall      = 1'b0;
    misaligned = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access_c) begin
          if (mis_c) begin
            misaligned = 1'b1;
          end else begin
            stall         = 1'b1;
            req_d.addr    = {addr[31:2], 2'b00};
            req_d.we      = memWrite;
            req_d.be      = be_c;
            req_d.wdata   = wdata_c;
            ld_d.size     = size;
            ld_d.uns      = unsignedLoad;
            ld_d.lane     = addr[1:0];
            state_d       = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        // An ack in the expiry cycle still completes normally.
        if (busAck) begin
          if (!req_q.we) load_d = ext_c;
          state_d = ST_DONE;
        end else if (expire_c) begin
          load_d  = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busReq   = (state_q == ST_WAIT);
  assign done     = (state_q == ST_DONE);
  assign busWe    = req_q.we;
  assign busAddr  = req_q.addr;
  assign busBe    = req_q.be;
  assign busWdata = req_q.wdata;
  assign loadData = load_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit plus reset and long-wait/timeout sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memRead, memWrite, unsignedLoad, busAck;
  logic [1:0]  size;
  logic [31:0] addr, wdata, busRdata;
  logic        busReq, busWe, stall, done, misaligned, busErr;
  logic [31:0] busAddr, busWdata, loadData;
  logic [3:0]  busBe;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .memRead(memRead), .memWrite(memWrite), .size(size),
    .unsignedLoad(unsignedLoad), .addr(addr), .wdata(wdata), .busReq(busReq), .busWe(busWe),
    .busAddr(busAddr), .busBe(busBe), .busWdata(busWdata), .busRdata(busRdata), .busAck(busAck),
    .stall(stall), .loadData(loadData), .done(done), .misaligned(misaligned), .busErr(busErr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    int          dly;
    logic [31:0] rdata;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] baddr;
    logic [31:0] bwd;
    logic [31:0] load;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] sz,
                              input logic uns, input logic [31:0] a, input logic [31:0] wd,
                              input int dly, input logic [31:0] rdata, input logic mis,
                              input logic [3:0] be, input logic [31:0] baddr,
                              input logic [31:0] bwd, input logic [31:0] load);
    vec_t v;
    v.rd = rd; v.wr = wr; v.sz = sz; v.uns = uns; v.addr = a; v.wd = wd; v.dly = dly;
    v.rdata = rdata; v.mis = mis; v.be = be; v.baddr = baddr; v.bwd = bwd; v.load = load;
    return v;
  endfunction

  task automatic idle_inputs();
    memRead = 1'b0; memWrite = 1'b0; size = 2'b00; unsignedLoad = 1'b0;
    addr = '0; wdata = '0; busAck = 1'b0; busRdata = 32'h5A5A_5A5A;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int stall_cnt;
    stall_cnt = 0;
    @(negedge clk);
    memRead = v.rd; memWrite = v.wr; size = v.sz; unsignedLoad = v.uns;
    addr = v.addr; wdata = v.wd;
    #1;
    chk({tag, ".mis"}, 32'(misaligned), 32'(v.mis));
    chk({tag, ".stall0"}, 32'(stall), 32'(!v.mis));
    if (stall) stall_cnt++;
    @(posedge clk); #1;
    memRead = 1'b0; memWrite = 1'b0;
    if (v.mis) begin
      @(negedge clk);
      chk({tag, ".mis_pulse"}, 32'(misaligned), 32'd0);
      chk({tag, ".no_req"}, 32'(busReq), 32'd0);
      chk({tag, ".no_done"}, 32'(done), 32'd0);
      chk({tag, ".load_keep"}, loadData, v.load);
      return;
    end
    for (int k = 0; k <= v.dly; k++) begin
      @(negedge clk);
      chk({tag, ".req"}, 32'(busReq), 32'd1);
      if (stall) stall_cnt++;
      if (k == 0) begin
        chk({tag, ".addr"}, busAddr, v.baddr);
        chk({tag, ".we"}, 32'(busWe), 32'(v.wr));
        chk({tag, ".be"}, 32'(busBe), 32'(v.be));
        if (v.wr) chk({tag, ".wdata"}, busWdata, v.bwd);
      end
      if (k == v.dly) begin
        busAck = 1'b1; busRdata = v.rdata;
        @(posedge clk); #1;
        busAck = 1'b0; busRdata = 32'h5A5A_5A5A;
      end
    end
    @(negedge clk);
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".stall_done"}, 32'(stall), 32'd0);
    chk({tag, ".req_done"}, 32'(busReq), 32'd0);
    chk({tag, ".err"}, 32'(busErr), 32'd0);
    chk({tag, ".load"}, loadData, v.load);
    chk({tag, ".stall_cycles"}, 32'(stall_cnt), 32'(v.dly + 2));
    @(negedge clk);
    chk({tag, ".done_pulse"}, 32'(done), 32'd0);
  endtask

  vec_t vecs[14];

  initial begin
    vecs[0]  = mk(1, 0, 2'b10, 0, 32'h0000_1004, 32'h0, 2, 32'hDEAD_BEEF, 0, 4'b1111, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF);
    vecs[1]  = mk(1, 0, 2'b00, 0, 32'h0000_2003, 32'h0, 0, 32'h8000_0000, 0, 4'b1111, 32'h0000_2000, 32'h0, 32'hFFFF_FF80);
    vecs[2]  = mk(1, 0, 2'b00, 1, 32'h0000_2003, 32'h0, 1, 32'h8000_0000, 0, 4'b1111, 32'h0000_2000, 32'h0, 32'h0000_0080);
    vecs[3]  = mk(0, 1, 2'b01, 0, 32'h0000_3002, 32'h1234_ABCD, 0, 32'hFFFF_FFFF, 0, 4'b1100, 32'h0000_3000, 32'hABCD_ABCD, 32'h0000_0080);
    vecs[4]  = mk(1, 0, 2'b01, 0, 32'h0000_0010, 32'h0, 0, 32'h1234_8001, 0, 4'b1111, 32'h0000_0010, 32'h0, 32'hFFFF_8001);
    vecs[5]  = mk(1, 0, 2'b01, 1, 32'h0000_0012, 32'h0, 0, 32'h8001_1234, 0, 4'b1111, 32'h0000_0010, 32'h0, 32'h0000_8001);
    vecs[6]  = mk(0, 1, 2'b00, 0, 32'h0000_0041, 32'h0000_55AA, 0, 32'hFFFF_FFFF, 0, 4'b0010, 32'h0000_0040, 32'hAAAA_AAAA, 32'h0000_8001);
    vecs[7]  = mk(0, 1, 2'b10, 0, 32'h0000_0080, 32'hCAFE_F00D, 2, 32'hFFFF_FFFF, 0, 4'b1111, 32'h0000_0080, 32'hCAFE_F00D, 32'h0000_8001);
    vecs[8]  = mk(1, 1, 2'b00, 0, 32'h0000_0043, 32'h0000_007F, 1, 32'hFFFF_FFFF, 0, 4'b1000, 32'h0000_0040, 32'h7F7F_7F7F, 32'h0000_8001);
    vecs[9]  = mk(1, 0, 2'b11, 0, 32'h0000_0100, 32'h0, 0, 32'h1122_3344, 0, 4'b1111, 32'h0000_0100, 32'h0, 32'h1122_3344);
    vecs[10] = mk(1, 0, 2'b10, 0, 32'h0000_0006, 32'h0, 0, 32'h0, 1, 4'b0000, 32'h0, 32'h0, 32'h1122_3344);
    vecs[11] = mk(0, 1, 2'b01, 0, 32'h0000_0021, 32'hFFFF, 0, 32'h0, 1, 4'b0000, 32'h0, 32'h0, 32'h1122_3344);
    vecs[12] = mk(1, 0, 2'b00, 0, 32'h0000_0201, 32'h0, 0, 32'h0000_7F00, 0, 4'b1111, 32'h0000_0200, 32'h0, 32'h0000_007F);
    vecs[13] = mk(1, 0, 2'b00, 0, 32'h0000_0302, 32'h0, 1, 32'h00C5_0000, 0, 4'b1111, 32'h0000_0300, 32'h0, 32'hFFFF_FFC5);

    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("rst.busReq", 32'(busReq), 32'd0);
    chk("rst.busWe", 32'(busWe), 32'd0);
    chk("rst.busBe", 32'(busBe), 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.misaligned", 32'(misaligned), 32'd0);
    chk("rst.busErr", 32'(busErr), 32'd0);
    chk("rst.busAddr", busAddr, 32'h0);
    chk("rst.busWdata", busWdata, 32'h0);
    chk("rst.loadData", loadData, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset during WAIT drops the request at once; a later stray ack is ignored.
    @(negedge clk);
    memRead = 1'b1; size = 2'b10; addr = 32'h0000_0600;
    @(posedge clk); #1;
    memRead = 1'b0;
    @(negedge clk);
    chk("rstwait.req_before", 32'(busReq), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstwait.req_drop", 32'(busReq), 32'd0);
    chk("rstwait.stall_drop", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; busAck = 1'b1; busRdata = 32'h1357_9BDF;
    @(posedge clk); #1;
    busAck = 1'b0;
    @(negedge clk);
    chk("rstwait.no_done", 32'(done), 32'd0);
    chk("rstwait.no_req", 32'(busReq), 32'd0);
    chk("rstwait.load", loadData, 32'h0);
    @(negedge clk);
    chk("rstwait.no_done2", 32'(done), 32'd0);

`ifdef BUS_TIMEOUT_EN
    // No ack: request for 4 cycles, then error completion with zeroed load data.
    @(negedge clk);
    memRead = 1'b1; size = 2'b10; addr = 32'h0000_0700;
    @(posedge clk); #1;
    memRead = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("tmo.req%0d", k), 32'(busReq), 32'd1);
    end
    @(negedge clk);
    chk("tmo.req_drop", 32'(busReq), 32'd0);
    chk("tmo.done", 32'(done), 32'd1);
    chk("tmo.err", 32'(busErr), 32'd1);
    chk("tmo.load", loadData, 32'h0);
    @(negedge clk);
    chk("tmo.err_pulse", 32'(busErr), 32'd0);
    chk("tmo.done_pulse", 32'(done), 32'd0);
    run_vec(mk(1, 0, 2'b10, 0, 32'h0000_0704, 32'h0, 3, 32'h2468_ACE0, 0, 4'b1111,
               32'h0000_0704, 32'h0, 32'h2468_ACE0), "tmo_ack");
`else
    // Without the timeout the request is held for as long as the ack takes.
    @(negedge clk);
    memRead = 1'b1; size = 2'b10; addr = 32'h0000_0700;
    @(posedge clk); #1;
    memRead = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("hold.req%0d", k), 32'(busReq), 32'd1);
      chk($sformatf("hold.stall%0d", k), 32'(stall), 32'd1);
    end
    busAck = 1'b1; busRdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    busAck = 1'b0;
    @(negedge clk);
    chk("hold.done", 32'(done), 32'd1);
    chk("hold.err", 32'(busErr), 32'd0);
    chk("hold.load", loadData, 32'h0BAD_F00D);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU. It takes the ALU result as the effective address and register rt as store data.
- Runs one data-memory transaction per load/store over a req/ack bus and stalls the core until the transaction completes.
- Handles byte/half/word sizing, lane steering, load sign/zero extension and misalignment detection.

Parameters:
- TIMEOUT_CYCLES, 256: ack wait limit; used only when BUS_TIMEOUT_EN is defined; legal range 2..65535.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- memRead  input  1  load requested by current instruction
- memWrite  input  1  store requested by current instruction
- size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- unsignedLoad  input  1  1 = zero-extend (lbu/lhu), 0 = sign-extend
- addr  input  32  effective address (ALU result)
- wdata  input  32  store data (rt)
- busReq  output  1  transaction request
- busWe  output  1  1 = write
- busAddr  output  32  word-aligned address, {addr[31:2],2'b00}
- busBe  output  4  byte enables, bit i = byte lane i
- busWdata  output  32  lane-replicated store data
- busRdata  input  32  read data, valid with busAck
- busAck  input  1  one-cycle completion pulse
- stall  output  1  core must hold PC/pipeline
- loadData  output  32  extended load result
- done  output  1  one-cycle completion pulse
- misaligned  output  1  address-exception pulse
- busErr  output  1  timeout pulse (BUS_TIMEOUT_EN only, else tied 0)

Behaviour:
Reset and priority:
- Reset (async, rst_n=0): state IDLE. busReq, busWe, busBe, stall, done, misaligned and busErr are 0. busAddr, busWdata and loadData are 32'h0.
- Reset mid-transaction drops busReq immediately. The in-flight ack is ignored.
- memWrite has priority if both memRead and memWrite are 1.

Endianness and lane rules:
- Little-endian. Lane = addr[1:0] for byte, addr[1] for half.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=0.

FSM: IDLE, WAIT, DONE.
- IDLE, access requested and aligned:
  - Register busAddr, busWe, busBe, busWdata and the load controls; next state WAIT.
  - stall=1 combinationally this cycle.
- IDLE, access requested and misaligned:
  - No bus access.
  - misaligned=1 combinationally.
  - stall=0, state stays IDLE.
- WAIT:
  - busReq=1, stall=1, request fields held stable.
  - On busAck: capture the extended busRdata into loadData (stores leave loadData unchanged); next state DONE.
- DONE:
  - done=1, stall=0, busReq=0; loadData stable.
  - Access inputs are ignored (same instruction retiring).
  - Unconditional next state IDLE.
- Latency: request cycle to done = 2 + N cycles, where N = wait cycles before busAck (N=0 when ack arrives in the first WAIT cycle).
- busAck while not in WAIT: ignored.

Store lane rules:
- byte: busBe = 1<<addr[1:0], busWdata = {4{wdata[7:0]}}
- half: busBe = addr[1] ? 1100 : 0011, busWdata = {2{wdata[15:0]}}
- word: busBe = 1111, busWdata = wdata
- Loads: busBe = 1111.

Load extraction: select the lane from busRdata, then extend to 32 bits per unsignedLoad.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined: a 16-bit counter clears on entry to WAIT and increments each WAIT cycle. If it reaches TIMEOUT_CYCLES-1 without busAck:
  - busReq drops.
  - busErr=1 for one cycle together with done=1.
  - loadData = 32'h0.
  - next state DONE.
  - An ack arriving in the same cycle as the timeout takes precedence (normal completion).
- Undefined: no counter; WAIT is held indefinitely; busErr tied 0.

Decomposition:
- Package lsu_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state enum (ST_IDLE, ST_WAIT, ST_DONE), TIMEOUT counter width.
- Sub-module lsu_align (combinational):
  - Produces busBe, busWdata and misaligned from size and addr[1:0].
  - Extracts and extends load data.
  - Instantiated once.

Test Plan:
- Load word: memRead=1, size=10, addr=32'h0000_1004, ack after 3 WAIT cycles with busRdata=32'hDEAD_BEEF -> busAddr=32'h0000_1004, busBe=1111, stall high for 4 cycles, done pulse, loadData=32'hDEAD_BEEF.
- Signed/unsigned byte: addr=32'h0000_2003, busRdata=32'h8000_0000 -> loadData=32'hFFFF_FF80 with unsignedLoad=0; 32'h0000_0080 with unsignedLoad=1.
- Store half: memWrite=1, size=01, addr=32'h0000_3002, wdata=32'h1234_ABCD, ack immediately -> busWe=1, busBe=1100, busWdata=32'hABCD_ABCD; done 2 cycles after the request cycle.
- Misaligned: size=10, addr=32'h0000_0006 -> misaligned=1 for one cycle, busReq never asserted, stall=0.
- Reset mid-WAIT: rst_n=0 during WAIT -> busReq=0 immediately; after release, state IDLE and a stray busAck causes no done.
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> busReq high 4 cycles, then busErr=1 and done=1, loadData=0.
